// File: rtl/cfg_frame_decoder_pkg.sv
// Shared types and constants for the config-bus frame decoder.
// Optional checksum byte is controlled by CFG_FRAME_CHECKSUM_EN.
package cfg_frame_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_ISSUE = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_BADCMD = 2'd1;
    localparam logic [1:0] ERR_CSUM   = 2'd2;
    localparam logic [1:0] ERR_TMO    = 2'd3;

    localparam logic [7:0] SOF_DEFAULT       = 8'hA5;
    localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h01;

    localparam int ADDR_BYTES = 2;
    localparam int DATA_BYTES = 4;
`ifdef CFG_FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = 9;
`else
    localparam int FRAME_LEN = 8;
`endif

endpackage

// File: rtl/cfg_frame_decoder_timer.sv
// Inter-byte idle counter: counts while run is high, cleared by clear or when not running.
// TIMEOUT_CYCLES = 0 removes the counter entirely and expired never asserts.
module frame_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            logic [W-1:0] count_reg;

            // Saturates at the limit so a long stall cannot wrap back below it.
            always_ff @(posedge clk) begin
                if (rst || clear || !run) begin
                    count_reg <= '0;
                end else if (count_reg < W'(TIMEOUT_CYCLES)) begin
                    count_reg <= count_reg + W'(1);
                end
            end

            assign expired = run && (count_reg >= W'(TIMEOUT_CYCLES));
        end else begin : g_no_timer
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cfg_frame_decoder.sv
// Parses SOF/CMD/ADDR/DATA[/CSUM] write frames from the CDC RX stream into single cfg_write strobes.
// Define CFG_FRAME_CHECKSUM_EN to require a trailing XOR checksum byte.
module cfg_frame_decoder
    import cfg_frame_decoder_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
    parameter logic [7:0] CMD_WRITE      = CMD_WRITE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] cfg_addr,
    output logic [31:0] cfg_wdata,
    output logic        cfg_write,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    state_t      state_reg;
    logic [1:0]  byte_idx_reg;
    logic [15:0] addr_stage_reg;
    logic [31:0] data_stage_reg;
    logic [15:0] cfg_addr_reg;
    logic [31:0] cfg_wdata_reg;
    logic        cfg_write_reg;
    logic        frame_err_reg;
    logic [1:0]  err_code_reg;
`ifdef CFG_FRAME_CHECKSUM_EN
    logic [7:0]  csum_reg;
`endif

    logic accept;
    logic timer_run;
    logic timeout_expired;

    assign rx_ready  = !rst && (state_reg != ST_ISSUE);
    assign accept    = rx_valid && rx_ready;
    assign timer_run = (state_reg != ST_IDLE) && (state_reg != ST_ISSUE);

    frame_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .run    (timer_run),
        .expired(timeout_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            byte_idx_reg   <= '0;
            addr_stage_reg <= '0;
            data_stage_reg <= '0;
            cfg_addr_reg   <= '0;
            cfg_wdata_reg  <= '0;
            cfg_write_reg  <= 1'b0;
            frame_err_reg  <= 1'b0;
            err_code_reg   <= ERR_NONE;
`ifdef CFG_FRAME_CHECKSUM_EN
            csum_reg       <= '0;
`endif
        end else begin
            cfg_write_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            // A byte arriving on the expiry cycle is dropped along with the frame.
            if (timeout_expired) begin
                state_reg     <= ST_IDLE;
                frame_err_reg <= 1'b1;
                err_code_reg  <= ERR_TMO;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (accept && rx_data == SOF_BYTE) begin
                            state_reg <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (accept) begin
                            if (rx_data == CMD_WRITE) begin
                                state_reg    <= ST_ADDR;
                                byte_idx_reg <= '0;
`ifdef CFG_FRAME_CHECKSUM_EN
                                csum_reg     <= rx_data;
`endif
                            end else begin
                                state_reg     <= ST_IDLE;
                                frame_err_reg <= 1'b1;
                                err_code_reg  <= ERR_BADCMD;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (accept) begin
                            addr_stage_reg <= {addr_stage_reg[7:0], rx_data};
`ifdef CFG_FRAME_CHECKSUM_EN
                            csum_reg       <= csum_reg ^ rx_data;
`endif
                            if (byte_idx_reg == 2'(ADDR_BYTES - 1)) begin
                                state_reg    <= ST_DATA;
                                byte_idx_reg <= '0;
                            end else begin
                                byte_idx_reg <= byte_idx_reg + 2'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (accept) begin
                            data_stage_reg <= {data_stage_reg[23:0], rx_data};
`ifdef CFG_FRAME_CHECKSUM_EN
                            csum_reg       <= csum_reg ^ rx_data;
`endif
                            if (byte_idx_reg == 2'(DATA_BYTES - 1)) begin
`ifdef CFG_FRAME_CHECKSUM_EN
                                state_reg     <= ST_CSUM;
`else
                                state_reg     <= ST_ISSUE;
                                cfg_addr_reg  <= addr_stage_reg;
                                cfg_wdata_reg <= {data_stage_reg[23:0], rx_data};
                                cfg_write_reg <= 1'b1;
`endif
                            end else begin
                                byte_idx_reg <= byte_idx_reg + 2'd1;
                            end
                        end
                    end
`ifdef CFG_FRAME_CHECKSUM_EN
                    ST_CSUM: begin
                        if (accept) begin
                            if (rx_data == csum_reg) begin
                                state_reg     <= ST_ISSUE;
                                cfg_addr_reg  <= addr_stage_reg;
                                cfg_wdata_reg <= data_stage_reg;
                                cfg_write_reg <= 1'b1;
                            end else begin
                                state_reg     <= ST_IDLE;
                                frame_err_reg <= 1'b1;
                                err_code_reg  <= ERR_CSUM;
                            end
                        end
                    end
`endif
                    ST_ISSUE: state_reg <= ST_IDLE;
                    default:  state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign cfg_addr  = cfg_addr_reg;
    assign cfg_wdata = cfg_wdata_reg;
    assign cfg_write = cfg_write_reg;
    assign frame_err = frame_err_reg;
    assign err_code  = err_code_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule
